// File: rtl/booth_mul_unit.sv
// Iterative radix-2 Booth signed multiplier for the EX stage.
// One Booth step per cycle; stalls the pipeline until the product is ready.
module booth_mul_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CODE = 4'd9,
    parameter int         CNT_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           alu_cnt,
    input  logic                 ex_valid,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 stall
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic                 start;
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       sum;

    assign start = ex_valid && (alu_cnt == MUL_CODE) && !flush;
    // A is one bit wider than M so that subtracting the most negative M cannot overflow.
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        unique case ({qr_q[0], qm1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        qr_d      = qr_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    qr_d    = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Arithmetic shift of {A, Q, q_m1} after the add/subtract step.
                    a_d   = {sum[WIDTH], sum[WIDTH:1]};
                    qr_d  = {sum[0], qr_q[WIDTH-1:1]};
                    qm1_d = qr_q[0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                product_d = {a_q[WIDTH-1:0], qr_q};
                done_d    = 1'b1;
                if (start) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    qr_d    = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            qr_q      <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            qr_q      <= qr_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q == S_RUN);
    assign stall   = busy;

endmodule

// File: tb/tb_booth_mul_unit.sv
// Self-checking bench for booth_mul_unit: scoreboard of expected products
// pushed at each start and popped when the done pulse is seen.
module tb_booth_mul_unit;

    localparam int         WIDTH    = 32;
    localparam logic [3:0] MUL_CODE = 4'd9;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           alu_cnt = '0;
    logic                 ex_valid = 1'b0;
    logic                 flush = 1'b0;
    logic [WIDTH-1:0]     multiplicand = '0;
    logic [WIDTH-1:0]     multiplier = '0;
    logic [2*WIDTH-1:0]   product;
    logic                 busy, done, stall;

    int                   checks = 0;
    int                   errors = 0;
    logic [2*WIDTH-1:0]   sb[$];
    logic [2*WIDTH-1:0]   last_product = '0;

    booth_mul_unit #(.WIDTH(WIDTH), .MUL_CODE(MUL_CODE), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .alu_cnt(alu_cnt), .ex_valid(ex_valid), .flush(flush),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        logic signed [2*WIDTH-1:0] sm, sq;
        sm = {{WIDTH{m[WIDTH-1]}}, m};
        sq = {{WIDTH{q[WIDTH-1]}}, q};
        return sm * sq;
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        multiplicand = m;
        multiplier   = q;
        alu_cnt      = MUL_CODE;
        ex_valid     = 1'b1;
        sb.push_back(model(m, q));
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        alu_cnt  = '0;
    endtask

    // Bounded wait for done; optionally injects a mid-run start or flush.
    task automatic wait_done(input int pulse_at, input int flush_at, input int limit,
                             output bit got, output int lat, output int busy_cnt,
                             output int stall_bad, output logic [2*WIDTH-1:0] obs);
        got = 1'b0; lat = 0; busy_cnt = 0; stall_bad = 0; obs = product;
        if (busy === 1'b1) busy_cnt++;
        if (stall !== busy) stall_bad++;
        while (!got && lat < limit) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (stall !== busy) stall_bad++;
            if (done === 1'b1) begin
                got = 1'b1;
                obs = product;
            end
            if (lat == pulse_at) begin
                multiplicand = $urandom; multiplier = $urandom;
                alu_cnt = MUL_CODE; ex_valid = 1'b1;
            end
            if (lat == pulse_at + 1) begin
                ex_valid = 1'b0; alu_cnt = '0;
            end
            if (lat == flush_at)     flush = 1'b1;
            if (lat == flush_at + 1) flush = 1'b0;
        end
    endtask

    task automatic run_and_compare(input string name, input logic [WIDTH-1:0] m,
                                   input logic [WIDTH-1:0] q, input int pulse_at);
        bit got; int lat, bc, sbad; logic [2*WIDTH-1:0] obs, exp;
        do_start(m, q);
        wait_done(pulse_at, -10, WIDTH + 10, got, lat, bc, sbad, obs);
        exp = sb.pop_front();
        checks++;
        if (!got || lat != WIDTH + 1) begin
            errors++; $display("FAIL %s_latency: got done=%0b after %0d cycles, required %0d", name, got, lat, WIDTH + 1);
        end
        checks++;
        if (bc != WIDTH || sbad != 0) begin
            errors++; $display("FAIL %s_busy: busy cycles %0d stall mismatches %0d, required %0d and 0", name, bc, sbad, WIDTH);
        end
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL %s_product: got %h required %h", name, obs, exp);
        end
        last_product = exp;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || product !== '0) begin
            errors++; $display("FAIL reset_state: busy=%b done=%b stall=%b product=%h, required all 0", busy, done, stall, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_and_compare("basic", 32'd7, 32'hFFFF_FFFD, -10);
        checks++;
        if (last_product !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL basic_model: got %h required %h", last_product, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || product !== last_product) begin
            errors++; $display("FAIL basic_done_pulse: done=%b product=%h, required 0 and %h", done, product, last_product);
        end
    endtask

    task automatic test_most_negative();
        run_and_compare("minmin", 32'h8000_0000, 32'h8000_0000, -10);
        checks++;
        if (last_product !== 64'h4000_0000_0000_0000) begin
            errors++; $display("FAIL minmin_value: got %h required 4000000000000000", last_product);
        end
        run_and_compare("min_one", 32'h8000_0000, 32'd1, -10);
        run_and_compare("zero", 32'd0, 32'hDEAD_BEEF, -10);
    endtask

    task automatic test_back_to_back();
        bit got; int lat, bc, sbad; logic [2*WIDTH-1:0] obs, exp;
        do_start(32'd3, 32'd5);
        repeat (WIDTH) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_done_state: busy=%b done=%b, required 0 0", busy, done);
        end
        multiplicand = 32'd12; multiplier = 32'd12; alu_cnt = MUL_CODE; ex_valid = 1'b1;
        sb.push_back(model(32'd12, 32'd12));
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; alu_cnt = '0;
        exp = sb.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || product !== exp) begin
            errors++; $display("FAIL b2b_first: done=%b busy=%b product=%h, required 1 1 %h", done, busy, product, exp);
        end
        wait_done(-10, -10, WIDTH + 10, got, lat, bc, sbad, obs);
        exp = sb.pop_front();
        checks++;
        if (!got || lat != WIDTH + 1 || obs !== exp || exp !== 64'h90) begin
            errors++; $display("FAIL b2b_second: done=%0b lat=%0d product=%h, required 1 %0d %h", got, lat, obs, WIDTH + 1, exp);
        end
        last_product = exp;
        run_and_compare("ignored_start", 32'd100, 32'hFFFF_FFF9, 8);
    endtask

    task automatic test_non_mul();
        int seen = 0;
        alu_cnt = 4'd2; ex_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) seen++;
        end
        alu_cnt = MUL_CODE; ex_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) seen++;
        end
        ex_valid = 1'b1; flush = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) seen++;
        end
        ex_valid = 1'b0; flush = 1'b0; alu_cnt = '0;
        checks++;
        if (seen != 0 || product !== last_product) begin
            errors++; $display("FAIL non_mul: activity cycles %0d product %h, required 0 and %h", seen, product, last_product);
        end
    endtask

    task automatic test_flush();
        bit got; int lat, bc, sbad; logic [2*WIDTH-1:0] obs, exp;
        do_start(32'd1234, 32'hFFFF_FFFB);
        wait_done(-10, 10, WIDTH + 5, got, lat, bc, sbad, obs);
        exp = sb.pop_front();
        checks++;
        if (got || bc != 11) begin
            errors++; $display("FAIL flush_abort: done=%0b busy cycles %0d, required 0 and 11", got, bc);
        end
        checks++;
        if (product !== last_product) begin
            errors++; $display("FAIL flush_hold: product %h required %h", product, last_product);
        end
        run_and_compare("after_flush", 32'hFFFF_FFF7, 32'd11, -10);
    endtask

    task automatic test_async_reset();
        do_start(32'h1234, 32'h55);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++; $display("FAIL async_reset: busy=%b stall=%b done=%b product=%h, required all 0", busy, stall, done, product);
        end
        sb.delete();
        last_product = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_and_compare("post_reset", 32'd5, 32'd6, -10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_and_compare("random", $urandom, $urandom, -10);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_most_negative();
        test_back_to_back();
        test_non_mul();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
